// File: rtl/rob.sv
// Reorder buffer: in-order allocation and retirement, out-of-order completion
// from ALU/branch/LSU, and squash of younger entries on a branch mispredict.
module rob #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_rd,
    input  logic [PREG_W-1:0] alloc_pd_new,
    input  logic [PREG_W-1:0] alloc_pd_old,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              alu_done,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic              br_done,
    input  logic [TAG_W-1:0]  br_tag,
    input  logic              lsu_done,
    input  logic [TAG_W-1:0]  lsu_tag,
    input  logic              mispredict,
    input  logic [TAG_W-1:0]  mispredict_tag,
    output logic              retire_valid,
    output logic [TAG_W-1:0]  retire_tag,
    output logic              retire_has_rd,
    output logic [PREG_W-1:0] retire_pd_old,
    output logic [PREG_W-1:0] retire_pd_new,
    output logic [TAG_W-1:0]  rob_head_tag,
    output logic              full,
    output logic              empty
);

    localparam logic [TAG_W:0] PTR_ONE   = (TAG_W+1)'(1);
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W:0]    head_q, tail_q, count, tail_mp;
    logic [TAG_W-1:0]  head_idx, tail_idx, br_age;
    logic [DEPTH-1:0]  valid_q, done_q, valid_next, done_next;
    logic [DEPTH-1:0]  squash, set_done;
    logic [DEPTH-1:0]  has_rd_q;
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic              alloc_fire, retire_fire;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign count    = tail_q - head_q;
    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);

    assign alloc_ready = !full && !mispredict;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_idx;

    assign retire_valid  = valid_q[head_idx] && done_q[head_idx];
    assign retire_fire   = retire_valid;
    assign retire_tag    = head_idx;
    assign rob_head_tag  = head_idx;
    assign retire_has_rd = retire_valid && has_rd_q[head_idx];
    assign retire_pd_old = retire_valid ? pd_old_q[head_idx] : '0;
    assign retire_pd_new = retire_valid ? pd_new_q[head_idx] : '0;

    // Age is measured from head, so "younger than the branch" is a plain
    // unsigned compare of head-relative offsets, independent of wrap.
    assign br_age  = mispredict_tag - head_idx;
    assign tail_mp = head_q + {1'b0, br_age} + PTR_ONE;

    always_comb begin
        squash   = '0;
        set_done = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash[i] = mispredict && ((TAG_W'(i) - head_idx) > br_age);
        end
        if (alu_done) set_done[alu_tag] = 1'b1;
        if (br_done)  set_done[br_tag]  = 1'b1;
        if (lsu_done) set_done[lsu_tag] = 1'b1;
        set_done = set_done & valid_q & ~squash;
    end

    always_comb begin
        valid_next = valid_q;
        done_next  = done_q | set_done;
        if (retire_fire) begin
            valid_next[head_idx] = 1'b0;
            done_next[head_idx]  = 1'b0;
        end
        if (alloc_fire) begin
            valid_next[tail_idx] = 1'b1;
            done_next[tail_idx]  = 1'b0;
        end
        valid_next = valid_next & ~squash;
        done_next  = done_next & ~squash;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            valid_q <= valid_next;
            done_q  <= done_next;
            if (retire_fire) head_q <= head_q + PTR_ONE;
            if (mispredict) tail_q <= tail_mp;
            else if (alloc_fire) tail_q <= tail_q + PTR_ONE;
        end
    end

    // NOTE: payload storage is deliberately not reset; it is only observed
    // through entries whose valid bit is set, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_rd_q[tail_idx] <= alloc_has_rd;
            pd_new_q[tail_idx] <= alloc_pd_new;
            pd_old_q[tail_idx] <= alloc_pd_old;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: a table of per-cycle vectors for the basic
// in-order retire flow, plus hand sequences for full, wrap, squash and reset.
module tb_rob;

    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int PREG_W = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_valid, alloc_ready, alloc_has_rd;
    logic [PREG_W-1:0] alloc_pd_new, alloc_pd_old;
    logic [TAG_W-1:0]  alloc_tag;
    logic              alu_done, br_done, lsu_done, mispredict;
    logic [TAG_W-1:0]  alu_tag, br_tag, lsu_tag, mispredict_tag;
    logic              retire_valid, retire_has_rd, full, empty;
    logic [TAG_W-1:0]  retire_tag, rob_head_tag;
    logic [PREG_W-1:0] retire_pd_old, retire_pd_new;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_rd(alloc_has_rd), .alloc_pd_new(alloc_pd_new),
        .alloc_pd_old(alloc_pd_old), .alloc_tag(alloc_tag),
        .alu_done(alu_done), .alu_tag(alu_tag),
        .br_done(br_done), .br_tag(br_tag),
        .lsu_done(lsu_done), .lsu_tag(lsu_tag),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .retire_valid(retire_valid), .retire_tag(retire_tag),
        .retire_has_rd(retire_has_rd), .retire_pd_old(retire_pd_old),
        .retire_pd_new(retire_pd_new), .rob_head_tag(rob_head_tag),
        .full(full), .empty(empty)
    );

    typedef struct {
        logic       av;
        logic [6:0] pdn, pdo;
        logic       ad;  logic [3:0] at;
        logic       bd;  logic [3:0] bt;
        logic       ld;  logic [3:0] lt;
        logic       e_ready;
        logic [3:0] e_tag;
        logic       e_rv;
        logic [3:0] e_rtag;
        logic [6:0] e_pdo, e_pdn;
        logic       e_empty, e_full;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        alloc_valid = 0; alloc_has_rd = 0; alloc_pd_new = '0; alloc_pd_old = '0;
        alu_done = 0; alu_tag = '0; br_done = 0; br_tag = '0;
        lsu_done = 0; lsu_tag = '0; mispredict = 0; mispredict_tag = '0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] tag_exp, input logic [6:0] pdn, input logic [6:0] pdo);
        alloc_valid = 1; alloc_has_rd = 1; alloc_pd_new = pdn; alloc_pd_old = pdo;
        #1;
        check("alloc_ready", alloc_ready, 1);
        check("alloc_tag", alloc_tag, tag_exp);
        step();
    endtask

    function automatic vec_t mk(input logic av, input logic [6:0] pdn, input logic [6:0] pdo,
                                input logic ad, input logic [3:0] at,
                                input logic bd, input logic [3:0] bt,
                                input logic ld, input logic [3:0] lt,
                                input logic [3:0] etag, input logic erv, input logic [3:0] ertag,
                                input logic [6:0] epdo, input logic [6:0] epdn, input logic eempty);
        vec_t r;
        r.av = av; r.pdn = pdn; r.pdo = pdo;
        r.ad = ad; r.at = at; r.bd = bd; r.bt = bt; r.ld = ld; r.lt = lt;
        r.e_ready = 1; r.e_tag = etag; r.e_rv = erv; r.e_rtag = ertag;
        r.e_pdo = epdo; r.e_pdn = epdn; r.e_empty = eempty; r.e_full = 0;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_in();
        reset = 1'b1;
        #12;
        check("rst alloc_ready", alloc_ready, 1);
        check("rst alloc_tag", alloc_tag, 0);
        check("rst retire_valid", retire_valid, 0);
        check("rst retire_tag", retire_tag, 0);
        check("rst retire_has_rd", retire_has_rd, 0);
        check("rst retire_pd_old", retire_pd_old, 0);
        check("rst retire_pd_new", retire_pd_new, 0);
        check("rst head_tag", rob_head_tag, 0);
        check("rst full", full, 0);
        check("rst empty", empty, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Allocate three, complete out of order, retire in order.
        //            av pdn pdo ad at bd bt ld lt  tag rv rtag pdo pdn empty
        vecs[0] = mk(1, 33, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1);
        vecs[1] = mk(1, 34, 2, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0);
        vecs[2] = mk(1, 35, 3, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0,  0);
        vecs[3] = mk(0,  0, 0, 1, 2, 0, 0, 0, 0,  3, 0, 0, 0, 0,  0);
        vecs[4] = mk(0,  0, 0, 0, 0, 1, 1, 0, 0,  3, 0, 0, 0, 0,  0);
        vecs[5] = mk(0,  0, 0, 0, 0, 0, 0, 1, 0,  3, 0, 0, 0, 0,  0);
        vecs[6] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 1, 33, 0);
        vecs[7] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  3, 1, 1, 2, 34, 0);
        vecs[8] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  3, 1, 2, 3, 35, 0);
        vecs[9] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0,  1);

        for (int i = 0; i < 10; i++) begin
            alloc_valid = vecs[i].av; alloc_has_rd = vecs[i].av;
            alloc_pd_new = vecs[i].pdn; alloc_pd_old = vecs[i].pdo;
            alu_done = vecs[i].ad; alu_tag = vecs[i].at;
            br_done = vecs[i].bd; br_tag = vecs[i].bt;
            lsu_done = vecs[i].ld; lsu_tag = vecs[i].lt;
            #1;
            check($sformatf("v%0d alloc_ready", i), alloc_ready, vecs[i].e_ready);
            check($sformatf("v%0d alloc_tag", i), alloc_tag, vecs[i].e_tag);
            check($sformatf("v%0d retire_valid", i), retire_valid, vecs[i].e_rv);
            check($sformatf("v%0d empty", i), empty, vecs[i].e_empty);
            check($sformatf("v%0d full", i), full, vecs[i].e_full);
            if (vecs[i].e_rv) begin
                check($sformatf("v%0d retire_tag", i), retire_tag, vecs[i].e_rtag);
                check($sformatf("v%0d retire_has_rd", i), retire_has_rd, 1);
                check($sformatf("v%0d retire_pd_old", i), retire_pd_old, vecs[i].e_pdo);
                check($sformatf("v%0d retire_pd_new", i), retire_pd_new, vecs[i].e_pdn);
            end
            step();
        end

        // Fill to full, then retire tag 0 and refill through the wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(4'(i), 7'(40 + i), 7'(i));
        alloc_valid = 1; alu_done = 1; alu_tag = 0;
        #1;
        check("full after 16", full, 1);
        check("ready on 17th", alloc_ready, 0);
        step();
        alloc_valid = 1;
        #1;
        check("full retire valid", retire_valid, 1);
        check("full retire tag", retire_tag, 0);
        check("full while retiring", full, 1);
        check("ready while retiring", alloc_ready, 0);
        step();
        check("not full after retire", full, 0);
        alloc(4'd0, 7'd99, 7'd9);
        #1;
        check("full after wrap alloc", full, 1);
        check("ready after wrap alloc", alloc_ready, 0);
        check("head after wrap", rob_head_tag, 1);
        step();

        // Mispredict at tag 3 with a same-cycle completion to squashed tag 5.
        do_reset();
        for (int i = 0; i < 8; i++) alloc(4'(i), 7'(20 + i), 7'(10 + i));
        alloc_valid = 1; mispredict = 1; mispredict_tag = 3; alu_done = 1; alu_tag = 5;
        #1;
        check("mp alloc_ready", alloc_ready, 0);
        step();
        #1;
        check("mp next alloc_tag", alloc_tag, 4);
        check("mp not empty", empty, 0);
        alu_done = 1; alu_tag = 0; br_done = 1; br_tag = 1; lsu_done = 1; lsu_tag = 2;
        step();
        alu_done = 1; alu_tag = 3; br_done = 1; br_tag = 5; lsu_done = 1; lsu_tag = 6;
        #1;
        check("mp retire tag0 valid", retire_valid, 1);
        check("mp retire tag0", retire_tag, 0);
        check("mp retire pd_old0", retire_pd_old, 10);
        step();
        for (int i = 1; i < 4; i++) begin
            #1;
            check("mp retire valid", retire_valid, 1);
            check("mp retire tag", retire_tag, 4'(i));
            check("mp retire pd_old", retire_pd_old, 7'(10 + i));
            step();
        end
        #1;
        check("mp empty (count 4)", empty, 1);
        check("mp no retire of squashed", retire_valid, 0);
        check("mp head tag", rob_head_tag, 4);
        check("mp alloc_tag after", alloc_tag, 4);

        // Wrapped window 14,15,0,1; mispredict at 15 while head 14 retires.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            alloc_valid = 1; alloc_has_rd = 1;
            alu_done = (i > 0); alu_tag = 4'(i - 1);
            step();
        end
        alu_done = 1; alu_tag = 13;
        step();
        for (int n = 0; n < 40 && !(empty && rob_head_tag == 14); n++) step();
        check("wrap head at 14", rob_head_tag, 14);
        check("wrap empty at 14", empty, 1);
        alloc(4'd14, 7'd64, 7'd14);
        alloc(4'd15, 7'd65, 7'd15);
        alloc(4'd0, 7'd66, 7'd16);
        alu_done = 1; alu_tag = 14;
        alloc(4'd1, 7'd67, 7'd17);
        alloc_valid = 1; mispredict = 1; mispredict_tag = 15; alu_done = 1; alu_tag = 1;
        #1;
        check("wrap retire during mp", retire_valid, 1);
        check("wrap retire tag 14", retire_tag, 14);
        check("wrap retire pd_old 14", retire_pd_old, 14);
        check("wrap mp alloc_ready", alloc_ready, 0);
        step();
        #1;
        check("wrap next alloc_tag", alloc_tag, 0);
        check("wrap head 15", rob_head_tag, 15);
        check("wrap not empty", empty, 0);
        br_done = 1; br_tag = 15; lsu_done = 1; lsu_tag = 1;
        step();
        #1;
        check("wrap retire 15", retire_valid, 1);
        check("wrap retire tag 15", retire_tag, 15);
        step();
        #1;
        check("wrap empty (count 2)", empty, 1);
        check("wrap no stale retire", retire_valid, 0);
        alloc(4'd0, 7'd70, 7'd30);
        #1;
        check("wrap new tag0 not done", retire_valid, 0);

        // Asynchronous reset with five live entries, head entry complete.
        do_reset();
        for (int i = 0; i < 5; i++) alloc(4'(i), 7'(50 + i), 7'(i));
        alu_done = 1; alu_tag = 0;
        step();
        #1;
        check("pre-reset retire_valid", retire_valid, 1);
        check("pre-reset alloc_tag", alloc_tag, 5);
        #2;
        reset = 1'b1;
        #1;
        check("async rst retire_valid", retire_valid, 0);
        check("async rst alloc_tag", alloc_tag, 0);
        check("async rst empty", empty, 1);
        check("async rst full", full, 0);
        check("async rst head", rob_head_tag, 0);
        check("async rst ready", alloc_ready, 1);
        check("async rst pd_old", retire_pd_old, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        alloc(4'd0, 7'd1, 7'd2);
        #1;
        check("post-rst alloc_tag", alloc_tag, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
